// File: rtl/pipe_pkg.sv
// pipe_pkg: shared decode constants for the 16-bit pipeline.
// Holds the opcode values, the pc_src encodings and the instruction field
// bit positions. It also holds the ID/EX control-bit indices and the NOP
// encoding used by the decode stage and its hazard unit.
package pipe_pkg;

    // Opcodes (instr[15:12]); anything not listed decodes as a NOP
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h3;
    localparam logic [3:0] OP_LW    = 4'h4;
    localparam logic [3:0] OP_SW    = 4'h5;
    localparam logic [3:0] OP_BEQ   = 4'h6;
    localparam logic [3:0] OP_BNE   = 4'h7;
    localparam logic [3:0] OP_J     = 4'h8;
    localparam logic [3:0] OP_JR    = 4'hA;

    // Fetch-stage next-PC selection
    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JMP = 2'b10,
        PCSRC_REG = 2'b11
    } pc_src_e;

    // Instruction field positions
    localparam int OP_HI    = 15;
    localparam int OP_LO    = 12;
    localparam int RD_HI    = 11;
    localparam int RD_LO    = 9;
    localparam int RS_HI    = 8;
    localparam int RS_LO    = 6;
    localparam int RT_HI    = 5;
    localparam int RT_LO    = 3;
    localparam int FN_HI    = 2;
    localparam int FN_LO    = 0;
    localparam int IMM6_HI  = 5;
    localparam int IMM12_HI = 11;

    // idex_ctrl = {regwrite, memread, memwrite, alusrc, aluop[3:0]}
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_ALUSRC   = 4;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: combinational stall detection for the decode stage.
// Ports:
//   op                 opcode of the instruction in IF/ID
//   reads_rs/reads_rt  whether that instruction actually reads each operand
//   rs_addr/rt_addr    operand register addresses
//   ex_rd, ex_regwrite, ex_memread  destination info of the instruction in EX
//   stall              load-use or branch/JR operand dependency on EX
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int RA = 3
) (
    input  logic [3:0]    op,
    input  logic          reads_rs,
    input  logic          reads_rt,
    input  logic [RA-1:0] rs_addr,
    input  logic [RA-1:0] rt_addr,
    input  logic [RA-1:0] ex_rd,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    output logic          stall
);

    logic rs_hit;
    logic rt_hit;
    logic is_ctrl;
    logic load_use;
    logic ctrl_dep;

    // R0 is hard-wired to zero, so a match on address 0 is never a dependency
    assign rs_hit  = reads_rs && (rs_addr != '0) && (ex_rd == rs_addr);
    assign rt_hit  = reads_rt && (rt_addr != '0) && (ex_rd == rt_addr);
    assign is_ctrl = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_JR);

    // Branch compare has no EX forwarding path, so any EX writer blocks it
    assign load_use = ex_memread && (rs_hit || rt_hit);
    assign ctrl_dep = is_ctrl && ex_regwrite && (rs_hit || rt_hit);
    assign stall    = load_use || ctrl_dep;

endmodule

// File: rtl/id_stage.sv
// id_stage: decode stage with IF/ID register, branch resolution and ID/EX bundle.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   if_pc, if_new_pc, if_instr  fetch-stage PC, PC+1 and instruction
//   rs_addr/rt_addr, rs_data/rt_data  register-file read port
//   ex_*, mem_*              downstream destination info and MEM forward value
//   stall, kill, pc_src      fetch controls; branch_ta/jump_ta/for_ta targets
//   idex_*                   registered bundle toward EX
//   stall_cycles, kill_count wrapping performance counters
// The second source register is instr[5:3] for R-type only; for SW, BEQ and
// BNE the [11:9] field names the second source, because imm6 overlaps [5:3].
module id_stage
    import pipe_pkg::*;
#(
    parameter int DW = 16,
    parameter int RA = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] if_pc,
    input  logic [DW-1:0] if_new_pc,
    input  logic [DW-1:0] if_instr,
    output logic [RA-1:0] rs_addr,
    output logic [RA-1:0] rt_addr,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic [RA-1:0] ex_rd,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    input  logic [RA-1:0] mem_rd,
    input  logic          mem_regwrite,
    input  logic [DW-1:0] mem_result,
    output logic          stall,
    output logic          kill,
    output logic [1:0]    pc_src,
    output logic [DW-1:0] branch_ta,
    output logic [DW-1:0] jump_ta,
    output logic [DW-1:0] for_ta,
    output logic [DW-1:0] idex_pc1,
    output logic [DW-1:0] idex_a,
    output logic [DW-1:0] idex_b,
    output logic [DW-1:0] idex_imm,
    output logic [RA-1:0] idex_rd,
    output logic [7:0]    idex_ctrl,
    output logic [DW-1:0] stall_cycles,
    output logic [DW-1:0] kill_count
);

    logic [DW-1:0] pc1;
    logic [DW-1:0] instr;
    logic [3:0]    op;
    logic [DW-1:0] imm6_sext;
    logic [DW-1:0] imm12_sext;
    logic          reads_rs;
    logic          reads_rt;
    logic [7:0]    ctrl;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    pc_src_e       pc_sel;

    // The current PC is carried by pc1 (PC+1); if_pc is informational only
    logic          unused_if_pc;
    assign unused_if_pc = ^if_pc;

    assign op         = instr[OP_HI:OP_LO];
    assign rs_addr    = instr[RS_HI:RS_LO];
    assign rt_addr    = (op == OP_RTYPE) ? instr[RT_HI:RT_LO] : instr[RD_HI:RD_LO];
    assign imm6_sext  = {{(DW-6){instr[IMM6_HI]}}, instr[IMM6_HI:0]};
    assign imm12_sext = {{(DW-12){instr[IMM12_HI]}}, instr[IMM12_HI:0]};

    // Control decode; the all-zero word is an explicit NOP even though its
    // opcode field equals R-type
    always_comb begin
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        ctrl     = 8'h00;
        if (instr != NOP_INSTR) begin
            case (op)
                OP_RTYPE: begin
                    reads_rs            = 1'b1;
                    reads_rt            = 1'b1;
                    ctrl[CTRL_REGWRITE] = 1'b1;
                    ctrl[3:0]           = {1'b0, instr[FN_HI:FN_LO]};
                end
                OP_ADDI: begin
                    reads_rs            = 1'b1;
                    ctrl[CTRL_REGWRITE] = 1'b1;
                    ctrl[CTRL_ALUSRC]   = 1'b1;
                end
                OP_LW: begin
                    reads_rs            = 1'b1;
                    ctrl[CTRL_REGWRITE] = 1'b1;
                    ctrl[CTRL_MEMREAD]  = 1'b1;
                    ctrl[CTRL_ALUSRC]   = 1'b1;
                end
                OP_SW: begin
                    reads_rs            = 1'b1;
                    reads_rt            = 1'b1;
                    ctrl[CTRL_MEMWRITE] = 1'b1;
                    ctrl[CTRL_ALUSRC]   = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    reads_rs = 1'b1;
                    reads_rt = 1'b1;
                end
                OP_JR: begin
                    reads_rs = 1'b1;
                end
                default: begin
                    reads_rs = 1'b0;
                end
            endcase
        end
    end

    hazard_unit #(.RA(RA)) u_hazard (
        .op          (op),
        .reads_rs    (reads_rs),
        .reads_rt    (reads_rt),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .ex_rd       (ex_rd),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .stall       (stall)
    );

    // MEM results feed the branch compare and JR target; EX forwards its own
    assign fwd_a = (mem_regwrite && (mem_rd == rs_addr) && (rs_addr != '0)) ? mem_result : rs_data;
    assign fwd_b = (mem_regwrite && (mem_rd == rt_addr) && (rt_addr != '0)) ? mem_result : rt_data;

    assign branch_ta = pc1 + imm6_sext;
    assign jump_ta   = pc1 + imm12_sext;
    assign for_ta    = fwd_a;

    // Redirect selection; a stall suppresses it so the branch re-evaluates
    always_comb begin
        pc_sel = PCSRC_SEQ;
        if (!stall) begin
            case (op)
                OP_BEQ:  pc_sel = (fwd_a == fwd_b) ? PCSRC_BR : PCSRC_SEQ;
                OP_BNE:  pc_sel = (fwd_a != fwd_b) ? PCSRC_BR : PCSRC_SEQ;
                OP_J:    pc_sel = PCSRC_JMP;
                OP_JR:   pc_sel = PCSRC_REG;
                default: pc_sel = PCSRC_SEQ;
            endcase
        end
    end

    assign pc_src = pc_sel;
    assign kill   = (pc_sel != PCSRC_SEQ);

    // IF/ID register: hold on stall, squash the wrong-path fetch on kill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc1   <= '0;
            instr <= NOP_INSTR;
        end else if (!stall) begin
            pc1   <= if_new_pc;
            instr <= kill ? NOP_INSTR : if_instr;
        end
    end

    // ID/EX bundle: a stall inserts an all-zero bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst || stall) begin
            idex_pc1  <= '0;
            idex_a    <= '0;
            idex_b    <= '0;
            idex_imm  <= '0;
            idex_rd   <= '0;
            idex_ctrl <= '0;
        end else begin
            idex_pc1  <= pc1;
            idex_a    <= rs_data;
            idex_b    <= rt_data;
            idex_imm  <= imm6_sext;
            idex_rd   <= instr[RD_HI:RD_LO];
            idex_ctrl <= ctrl;
        end
    end

    // Performance counters, wrapping naturally at DW bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            kill_count   <= '0;
        end else begin
            if (stall) stall_cycles <= stall_cycles + DW'(1);
            if (kill)  kill_count   <= kill_count + DW'(1);
        end
    end

endmodule
